// File: rtl/ffstdp_sweep_ctrl_pkg.sv
// Shared types and defaults for the FF-STDP sweep controller and the update stage.
// Holds the sweep FSM encoding, array geometry defaults and synapse address packing.
package ffstdp_sweep_ctrl_pkg;

    localparam int DEF_N_PRE    = 256;
    localparam int DEF_N_POST   = 16;
    localparam int DEF_PRE_AW   = 8;
    localparam int DEF_POST_AW  = 4;
    localparam int DEF_PIPE_LAT = 2;
    localparam int DEF_SYN_AW   = DEF_PRE_AW + DEF_POST_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_t;

    typedef logic [DEF_SYN_AW-1:0] syn_addr_t;

    // Synapse SRAM address: pre row in the upper field, post column in the lower.
    function automatic syn_addr_t syn_addr(input logic [DEF_PRE_AW-1:0]  pre_idx,
                                           input logic [DEF_POST_AW-1:0] post_idx);
        return {pre_idx, post_idx};
    endfunction

endpackage

// File: rtl/ffstdp_addr_delay.sv
// Fixed-depth valid+address delay line; DEPTH cycles in to out, first tap after one cycle.
// Not stallable: no backpressure, every entry retires exactly DEPTH cycles after entry.
module ffstdp_addr_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          tap0_vld,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    addr_q [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_vld;
            addr_q[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign tap0_vld = vld_q[0];
    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/ffstdp_sweep_ctrl.sv
// Walks every (pre, post) synapse once per training START: one read per cycle,
// write-back PIPE_LAT cycles later, DONE after the last write; no backpressure, START ignored while busy.
module ffstdp_sweep_ctrl
    import ffstdp_sweep_ctrl_pkg::*;
#(
    parameter int N_PRE    = DEF_N_PRE,
    parameter int N_POST   = DEF_N_POST,
    parameter int PRE_AW   = DEF_PRE_AW,
    parameter int POST_AW  = DEF_POST_AW,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      IS_TRAIN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      SYN_RE,
    output logic [PRE_AW+POST_AW-1:0] SYN_RADDR,
    output logic                      CNT_RE,
    output logic [PRE_AW-1:0]         PRE_CNT_ADDR,
    output logic [POST_AW-1:0]        POST_CNT_ADDR,
    output logic                      CTRL_TREF_EVENT,
    output logic                      SYN_WE,
    output logic [PRE_AW+POST_AW-1:0] SYN_WADDR
);

    localparam int SAW = PRE_AW + POST_AW;
    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    sweep_state_t       state_q, state_d;
    logic [PRE_AW-1:0]  pre_q, pre_d;
    logic [POST_AW-1:0] post_q, post_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic               done_q, done_d;
    logic               issue;
    logic               last_pre, last_post;
    logic [SAW-1:0]     raddr;

    // Wrap on compare so non-power-of-2 geometries never visit unused indices.
    assign last_pre  = (pre_q == PRE_AW'(N_PRE - 1));
    assign last_post = (post_q == POST_AW'(N_POST - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            post_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        post_d  = post_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && IS_TRAIN) begin
                    state_d = ST_SWEEP;
                    pre_d   = '0;
                    post_d  = '0;
                end
            end
            ST_SWEEP: begin
                issue = 1'b1;
                if (last_post) begin
                    post_d = '0;
                    if (last_pre) begin
                        pre_d   = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        pre_d = pre_q + PRE_AW'(1);
                    end
                end else begin
                    post_d = post_q + POST_AW'(1);
                end
            end
            ST_DRAIN: begin
                // Hold until the last issued address has left the delay line.
                if (drain_q == DCW'(PIPE_LAT - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign raddr         = issue ? {pre_q, post_q} : '0;
    assign SYN_RE        = issue;
    assign CNT_RE        = issue;
    assign SYN_RADDR     = raddr;
    assign PRE_CNT_ADDR  = issue ? pre_q : '0;
    assign POST_CNT_ADDR = issue ? post_q : '0;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = done_q;

    ffstdp_addr_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (SAW)
    ) u_wb_delay (
        .CLK      (CLK),
        .RST      (RST),
        .in_vld   (issue),
        .in_addr  (raddr),
        .tap0_vld (CTRL_TREF_EVENT),
        .out_vld  (SYN_WE),
        .out_addr (SYN_WADDR)
    );

endmodule

// File: tb/tb_ffstdp_sweep_ctrl.sv
// Directed plus random START/IS_TRAIN/RST stimulus against a cycle-offset model of the sweep.
module tb_ffstdp_sweep_ctrl;

    localparam int NPRE   = 4;
    localparam int NPOST  = 3;
    localparam int PREAW  = 2;
    localparam int POSTAW = 2;
    localparam int PLAT   = 2;
    localparam int NT     = NPRE * NPOST;

    logic                    CLK;
    logic                    RST;
    logic                    START;
    logic                    IS_TRAIN;
    logic                    BUSY;
    logic                    DONE;
    logic                    SYN_RE;
    logic [PREAW+POSTAW-1:0] SYN_RADDR;
    logic                    CNT_RE;
    logic [PREAW-1:0]        PRE_CNT_ADDR;
    logic [POSTAW-1:0]       POST_CNT_ADDR;
    logic                    CTRL_TREF_EVENT;
    logic                    SYN_WE;
    logic [PREAW+POSTAW-1:0] SYN_WADDR;

    ffstdp_sweep_ctrl #(
        .N_PRE    (NPRE),
        .N_POST   (NPOST),
        .PRE_AW   (PREAW),
        .POST_AW  (POSTAW),
        .PIPE_LAT (PLAT)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .START           (START),
        .IS_TRAIN        (IS_TRAIN),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .SYN_RE          (SYN_RE),
        .SYN_RADDR       (SYN_RADDR),
        .CNT_RE          (CNT_RE),
        .PRE_CNT_ADDR    (PRE_CNT_ADDR),
        .POST_CNT_ADDR   (POST_CNT_ADDR),
        .CTRL_TREF_EVENT (CTRL_TREF_EVENT),
        .SYN_WE          (SYN_WE),
        .SYN_WADDR       (SYN_WADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_done   = 0;

    // Reference: a sweep is a cycle offset k from the cycle START was sampled in.
    bit m_act = 0;
    int m_k   = 0;

    function automatic int exp_addr(input int i);
        return ((i / NPOST) << POSTAW) | (i % NPOST);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit busy_e, re_e, tref_e, we_e, done_e;
        busy_e = m_act && m_k >= 1 && m_k <= NT + PLAT;
        re_e   = m_act && m_k >= 1 && m_k <= NT;
        tref_e = m_act && m_k >= 2 && m_k <= NT + 1;
        we_e   = m_act && m_k >= 1 + PLAT && m_k <= NT + PLAT;
        done_e = m_act && m_k == NT + PLAT + 1;
        chk("busy", 32'(BUSY), 32'(busy_e));
        chk("syn_re", 32'(SYN_RE), 32'(re_e));
        chk("cnt_re", 32'(CNT_RE), 32'(re_e));
        chk("tref", 32'(CTRL_TREF_EVENT), 32'(tref_e));
        chk("syn_we", 32'(SYN_WE), 32'(we_e));
        chk("done", 32'(DONE), 32'(done_e));
        if (re_e) begin
            chk("syn_raddr", 32'(SYN_RADDR), 32'(exp_addr(m_k - 1)));
            chk("pre_cnt_addr", 32'(PRE_CNT_ADDR), 32'((m_k - 1) / NPOST));
            chk("post_cnt_addr", 32'(POST_CNT_ADDR), 32'((m_k - 1) % NPOST));
        end
        if (we_e) begin
            chk("syn_waddr", 32'(SYN_WADDR), 32'(exp_addr(m_k - 1 - PLAT)));
        end
        if (SYN_WE === 1'b1) n_we++;
        if (DONE === 1'b1) n_done++;
    endtask

    // One clock: check current outputs, drive inputs for the coming edge, advance model.
    task automatic cycle(input logic st, input logic tr, input logic rs);
        bit busy_now;
        @(negedge CLK);
        check_outputs();
        START    = st;
        IS_TRAIN = tr;
        RST      = rs;
        busy_now = m_act && m_k >= 1 && m_k <= NT + PLAT;
        @(posedge CLK);
        if (rs) begin
            m_act = 0;
            m_k   = 0;
        end else if (st && tr && !busy_now) begin
            m_act = 1;
            m_k   = 1;
        end else if (m_act) begin
            m_k++;
            if (m_k > NT + PLAT + 1) begin
                m_act = 0;
                m_k   = 0;
            end
        end
    endtask

    initial begin
        int we0, done0;
        RST = 1'b1; START = 1'b0; IS_TRAIN = 1'b0;
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Single sweep from START in c0.
        we0 = n_we; done0 = n_done;
        cycle(1, 1, 0);
        for (int i = 1; i <= NT + 5; i++) cycle(0, 1, 0);
        chk("sweep1_writes", 32'(n_we - we0), 32'(NT));
        chk("sweep1_dones", 32'(n_done - done0), 32'd1);

        // START without IS_TRAIN.
        we0 = n_we;
        cycle(1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0);
        chk("notrain_writes", 32'(n_we - we0), 32'd0);

        // Extra START in c5 is ignored; IS_TRAIN drops mid-sweep.
        we0 = n_we; done0 = n_done;
        cycle(1, 1, 0);
        for (int i = 1; i <= NT + 5; i++) cycle(i == 5, i < 8, 0);
        chk("restart_writes", 32'(n_we - we0), 32'(NT));
        chk("restart_dones", 32'(n_done - done0), 32'd1);

        // Reset in c7, then a fresh sweep from address 0.
        cycle(1, 1, 0);
        for (int i = 1; i <= 6; i++) cycle(0, 1, 0);
        cycle(0, 1, 1);
        we0 = n_we; done0 = n_done;
        for (int i = 0; i < 10; i++) cycle(0, 1, 0);
        chk("post_reset_writes", 32'(n_we - we0), 32'd0);
        chk("post_reset_dones", 32'(n_done - done0), 32'd0);
        cycle(1, 1, 0);
        for (int i = 1; i <= NT + 4; i++) cycle(0, 1, 0);

        // Back-to-back: second START in the DONE cycle of the first.
        we0 = n_we; done0 = n_done;
        cycle(1, 1, 0);
        for (int i = 1; i <= NT + PLAT + 1; i++) cycle(i == NT + PLAT + 1, 1, 0);
        for (int i = 1; i <= NT + 5; i++) cycle(0, 0, 0);
        chk("b2b_writes", 32'(n_we - we0), 32'(2 * NT));
        chk("b2b_dones", 32'(n_done - done0), 32'd2);

        // Random START/IS_TRAIN pulses with occasional resets.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < NT + 5; i++) cycle(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
